gray_counter: RTL and testbench
===============================

// Module: gray_counter
//
// PURPOSE
//   Binary-to-Gray direction of the Gray-code path: a synchronous up/down counter
//   whose primary output is the registered Gray code of its count.
//   Successive outputs differ in exactly one bit, so it can drive cross-domain
//   pointers and position encoders. Its Gray output feeds the existing
//   Gray-to-binary decoder on the far side.
//
// PARAMETERS
//   WIDTH  32  counter / code width in bits (>= 2)
//   WRAP   1   1: wrap around modulo 2**WIDTH; 0: saturate at 0 and 2**WIDTH-1
//
// PORTS
//   clk    in   1      clock, all state updates on rising edge
//   rst    in   1      asynchronous reset, active-high
//   en     in   1      count enable: one step per cycle while high
//   up     in   1      direction: 1 = increment, 0 = decrement
//   load   in   1      load d into the counter this cycle
//   d      in   WIDTH  binary load value
//   gray   out  WIDTH  registered Gray code of the count
//   bin    out  WIDTH  registered binary count
//   tc     out  1      terminal-count pulse (registered, 1 cycle)
//
// BEHAVIOUR
//   - Reset (async assert, release sync to clk): bin=0, gray=0, tc=0; applies mid-operation, no partial step.
//   - Per rising edge, priority load > en > hold:
//       load=1            : bin<=d, gray<=d^(d>>1), tc<=0 (en, up ignored)
//       load=0,en=1,up=1  : bin<=bin+1 (mod 2**WIDTH)
//       load=0,en=1,up=0  : bin<=bin-1 (mod 2**WIDTH)
//       load=0,en=0       : hold; tc<=0
//   - gray is a flop loaded with bin_to_gray(next bin), never decoded from bin combinationally;
//     gray==bin^(bin>>1) in every cycle.
//   - Latency: one cycle from en/load sampled to new gray/bin visible.
//   - Boundary, WRAP=1: up at 2**WIDTH-1 -> 0, down at 0 -> 2**WIDTH-1; tc=1 in the
//     cycle the wrapped value appears, 0 otherwise.
//   - Boundary, WRAP=0: up at max or down at 0 holds the value; tc=1 the next
//     cycle for each blocked step; normal steps give tc=0.
//   - While counting (no load), consecutive gray values differ in exactly one bit;
//     the same holds across a wrap. A load may change any number of bits.
//   - Direction may change on any cycle; the step uses the up value sampled that edge.
//   - No illegal states: all 2**WIDTH values are valid.
//
// STRUCTURE
//   - Package gray_pkg: function bin_to_gray(logic [WIDTH-1:0]) (b ^ (b >> 1)).
//     Also localparam DEFAULT_WIDTH = 32, shared with the Gray-to-binary side.
//   - Sub-module gray_step: combinational next-state (load/en/up/WRAP mux, limit
//     detect, tc_next); gray_counter holds only the registers.
//
// TESTING  (WIDTH=4 unless stated)
//   1 reset, en=1 up=1 for 5 cycles -> gray 0000,0001,0011,0010,0110,0111; tc=0
//   2 load d=1111, en=1 up=1 -> bin 0000 gray 0000 tc=1; next cycle tc=0
//   3 from 0, en=1 up=0 -> bin 1111 gray 1000 tc=1; next step bin 1110 gray 1001
//   4 load=1 en=1 d=1010 same cycle -> bin 1010 gray 1111 (load wins), tc=0
//   5 WRAP=0, at bin 1111, en=1 up=1 x2 -> bin stays 1111, tc=1 both cycles;
//     up=0 -> bin 1110, tc=0
//   6 assert rst mid-count at bin 0110 -> gray/bin/tc 0 before next clk edge;
//     random run of 10^4 steps: popcount(gray^gray_prev)==1 on every non-load step

Source files
------------

// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gray_pkg
// Description : Shared Gray-code width default and binary-to-Gray conversion.
// Revision    : 1.0 - initial release
// ============================================================================
package gray_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    // Widest code the conversion helper handles; callers zero-extend and truncate.
    localparam int GRAY_MAX_WIDTH = 128;

    typedef logic [GRAY_MAX_WIDTH-1:0] grayWide_t;

    function automatic grayWide_t bin_to_gray(input grayWide_t b);
        return b ^ (b >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray_step.sv
`default_nettype none
// ============================================================================
// Module      : gray_step
// Description : Next-state logic for gray_counter: load/step mux, limit
//               detection, terminal-count and next Gray code.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_step
    import gray_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter bit WRAP  = 1'b1
) (
    input  logic [WIDTH-1:0] bin,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] binNext,
    output logic [WIDTH-1:0] grayNext,
    output logic             tcNext
);

    localparam logic [WIDTH-1:0] c_maxCount = '1;

    logic             w_atLimit;
    logic [WIDTH-1:0] w_stepped;

    always_comb begin
        w_atLimit = up ? (bin == c_maxCount) : (bin == '0);
        w_stepped = up ? (bin + WIDTH'(1)) : (bin - WIDTH'(1));

        binNext = bin;
        tcNext  = 1'b0;
        if (load) begin
            binNext = d;
        end else if (en) begin
            // A step off either end flags tc whether it wraps or is blocked.
            tcNext = w_atLimit;
            if (!w_atLimit || WRAP) begin
                binNext = w_stepped;
            end
        end

        grayNext = WIDTH'(bin_to_gray(GRAY_MAX_WIDTH'(binNext)));
    end

endmodule
`default_nettype wire

// File: rtl/gray_counter.sv
`default_nettype none
// ============================================================================
// Module      : gray_counter
// Description : Up/down counter with registered binary count, registered
//               Gray code of that count and a one-cycle terminal-count pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,   // 2 .. GRAY_MAX_WIDTH
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin,
    output logic             tc
);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_tc;

    logic [WIDTH-1:0] w_binNext;
    logic [WIDTH-1:0] w_grayNext;
    logic             w_tcNext;

    gray_step #(
        .WIDTH (WIDTH),
        .WRAP  (WRAP)
    ) u_step (
        .bin      (r_bin),
        .en       (en),
        .up       (up),
        .load     (load),
        .d        (d),
        .binNext  (w_binNext),
        .grayNext (w_grayNext),
        .tcNext   (w_tcNext)
    );

    // Gray is its own flop so the output never glitches through decode logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin  <= '0;
            r_gray <= '0;
            r_tc   <= 1'b0;
        end else begin
            r_bin  <= w_binNext;
            r_gray <= w_grayNext;
            r_tc   <= w_tcNext;
        end
    end

    assign bin  = r_bin;
    assign gray = r_gray;
    assign tc   = r_tc;

endmodule
`default_nettype wire

// File: tb/tb_gray_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_counter
// Description : Self-checking bench for gray_counter, WIDTH=4, wrapping and
//               saturating instances driven with the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0, up = 1'b0, load = 1'b0;
    logic [W-1:0] d = '0;
    logic [W-1:0] grayW, binW, grayS, binS;
    logic         tcW, tcS;

    int checks = 0;
    int failures = 0;

    // Reference model state: plain integer count and tc per instance.
    int mbW = 0, mtW = 0, mbS = 0, mtS = 0;
    int grayTab[16];

    gray_counter #(.WIDTH(W), .WRAP(1'b1)) dutWrap (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
        .gray(grayW), .bin(binW), .tc(tcW)
    );

    gray_counter #(.WIDTH(W), .WRAP(1'b0)) dutSat (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
        .gray(grayS), .bin(binS), .tc(tcS)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, time=%0t required<1000000", $time);
        $fatal(1, "timeout");
    end

    // Reflected Gray code sequence built by mirroring, independent of XOR form.
    task automatic build_gray_table();
        int size = 1;
        grayTab[0] = 0;
        for (int b = 0; b < W; b++) begin
            for (int i = 0; i < size; i++) grayTab[2*size-1-i] = grayTab[i] | (1 << b);
            size = size * 2;
        end
    endtask

    task automatic model_step(input bit wrap, inout int mb, inout int mt);
        int nxt;
        if (rst) begin
            mb = 0; mt = 0;
        end else if (load) begin
            mb = int'(d); mt = 0;
        end else if (en) begin
            nxt = up ? mb + 1 : mb - 1;
            if (nxt < 0 || nxt > 15) begin
                mt = 1;
                if (wrap) mb = (nxt + 16) % 16;
            end else begin
                mb = nxt; mt = 0;
            end
        end else begin
            mt = 0;
        end
    endtask

    // One clock: model follows the inputs sampled at the edge; returns 1 after it.
    task automatic tick();
        @(posedge clk);
        model_step(1'b1, mbW, mtW);
        model_step(1'b0, mbS, mtS);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 0; up = 0; load = 0; d = '0;
        #12;
        checks++; if (binW !== 4'b0000) begin failures++; $display("FAIL reset_bin: got %b want 0000", binW); end
        checks++; if (grayW !== 4'b0000) begin failures++; $display("FAIL reset_gray: got %b want 0000", grayW); end
        checks++; if (tcW !== 1'b0 || tcS !== 1'b0) begin failures++; $display("FAIL reset_tc: got %b/%b want 0/0", tcW, tcS); end
        @(posedge clk); #1; rst = 1'b0;
        mbW = 0; mtW = 0; mbS = 0; mtS = 0;
    endtask

    task automatic test_count_up();
        logic [W-1:0] expG [5] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111};
        en = 1; up = 1; load = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (grayW !== expG[i]) begin failures++; $display("FAIL count_up_gray[%0d]: got %b want %b", i, grayW, expG[i]); end
            checks++; if (binW !== W'(i + 1)) begin failures++; $display("FAIL count_up_bin[%0d]: got %b want %0d", i, binW, i + 1); end
            checks++; if (tcW !== 1'b0) begin failures++; $display("FAIL count_up_tc[%0d]: got %b want 0", i, tcW); end
        end
        en = 0;
    endtask

    task automatic test_wrap_up();
        load = 1; d = 4'b1111; en = 0;
        tick();
        checks++; if (grayW !== 4'b1000) begin failures++; $display("FAIL load_f_gray: got %b want 1000", grayW); end
        load = 0; en = 1; up = 1;
        tick();
        checks++; if (binW !== 4'b0000 || grayW !== 4'b0000) begin failures++; $display("FAIL wrap_up_val: got bin %b gray %b want 0000/0000", binW, grayW); end
        checks++; if (tcW !== 1'b1) begin failures++; $display("FAIL wrap_up_tc: got %b want 1", tcW); end
        tick();
        checks++; if (tcW !== 1'b0 || binW !== 4'b0001) begin failures++; $display("FAIL wrap_up_after: got tc %b bin %b want 0/0001", tcW, binW); end
        en = 0;
    endtask

    task automatic test_wrap_down();
        load = 1; d = 4'b0000; en = 0;
        tick();
        load = 0; en = 1; up = 0;
        tick();
        checks++; if (binW !== 4'b1111 || grayW !== 4'b1000) begin failures++; $display("FAIL wrap_down_val: got bin %b gray %b want 1111/1000", binW, grayW); end
        checks++; if (tcW !== 1'b1) begin failures++; $display("FAIL wrap_down_tc: got %b want 1", tcW); end
        checks++; if (binS !== 4'b0000 || tcS !== 1'b1) begin failures++; $display("FAIL sat_down_hold: got bin %b tc %b want 0000/1", binS, tcS); end
        tick();
        checks++; if (binW !== 4'b1110 || grayW !== 4'b1001 || tcW !== 1'b0) begin failures++; $display("FAIL wrap_down_next: got bin %b gray %b tc %b want 1110/1001/0", binW, grayW, tcW); end
        en = 0;
    endtask

    task automatic test_load_priority();
        load = 1; d = 4'b1111; en = 0;
        tick();
        load = 1; en = 1; up = 1; d = 4'b1010;
        tick();
        checks++; if (binW !== 4'b1010 || grayW !== 4'b1111) begin failures++; $display("FAIL load_prio_val: got bin %b gray %b want 1010/1111", binW, grayW); end
        checks++; if (tcW !== 1'b0) begin failures++; $display("FAIL load_prio_tc: got %b want 0", tcW); end
        load = 0; en = 0;
    endtask

    task automatic test_saturate();
        load = 1; d = 4'b1111; en = 0;
        tick();
        load = 0; en = 1; up = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (binS !== 4'b1111 || grayS !== 4'b1000) begin failures++; $display("FAIL sat_up_hold[%0d]: got bin %b gray %b want 1111/1000", i, binS, grayS); end
            checks++; if (tcS !== 1'b1) begin failures++; $display("FAIL sat_up_tc[%0d]: got %b want 1", i, tcS); end
        end
        up = 0;
        tick();
        checks++; if (binS !== 4'b1110 || grayS !== 4'b1001 || tcS !== 1'b0) begin failures++; $display("FAIL sat_down_step: got bin %b gray %b tc %b want 1110/1001/0", binS, grayS, tcS); end
        en = 0;
    endtask

    task automatic test_async_reset();
        load = 1; d = 4'b0101; en = 0;
        tick();
        load = 0; en = 1; up = 1;
        tick();
        checks++; if (binW !== 4'b0110 || grayW !== 4'b0101) begin failures++; $display("FAIL pre_reset_val: got bin %b gray %b want 0110/0101", binW, grayW); end
        #2; rst = 1'b1;
        #1;
        checks++; if (binW !== 4'b0000 || grayW !== 4'b0000 || tcW !== 1'b0) begin failures++; $display("FAIL async_reset: got bin %b gray %b tc %b want 0", binW, grayW, tcW); end
        checks++; if (binS !== 4'b0000 || grayS !== 4'b0000) begin failures++; $display("FAIL async_reset_sat: got bin %b gray %b want 0", binS, grayS); end
        tick();
        checks++; if (binW !== 4'b0000) begin failures++; $display("FAIL reset_held: got bin %b want 0000", binW); end
        rst = 1'b0; en = 0;
    endtask

    task automatic test_random();
        logic [W-1:0] prevW, prevS;
        bit wasLoad, wasEn;
        for (int i = 0; i < 10000; i++) begin
            load = ($urandom_range(15) == 0);
            en   = ($urandom_range(3) != 0);
            up   = $urandom_range(1);
            d    = W'($urandom);
            wasLoad = load; wasEn = en;
            prevW = grayW; prevS = grayS;
            tick();
            checks++; if (binW !== W'(mbW) || grayW !== W'(grayTab[mbW]) || tcW !== mtW[0]) begin
                failures++; $display("FAIL rand_wrap[%0d]: got bin %b gray %b tc %b want %0d/%b/%0d", i, binW, grayW, tcW, mbW, W'(grayTab[mbW]), mtW);
            end
            checks++; if (binS !== W'(mbS) || grayS !== W'(grayTab[mbS]) || tcS !== mtS[0]) begin
                failures++; $display("FAIL rand_sat[%0d]: got bin %b gray %b tc %b want %0d/%b/%0d", i, binS, grayS, tcS, mbS, W'(grayTab[mbS]), mtS);
            end
            if (!wasLoad && wasEn) begin
                checks++; if ($countones(grayW ^ prevW) != 1) begin failures++; $display("FAIL rand_onebit[%0d]: got %b->%b want 1 bit change", i, prevW, grayW); end
            end else if (!wasLoad) begin
                checks++; if (grayW !== prevW || grayS !== prevS) begin failures++; $display("FAIL rand_hold[%0d]: got %b/%b want %b/%b", i, grayW, grayS, prevW, prevS); end
            end
        end
        load = 0; en = 0;
    endtask

    initial begin
        build_gray_table();
        test_reset();
        test_count_up();
        test_wrap_up();
        test_wrap_down();
        test_load_priority();
        test_saturate();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
